// File: rtl/program_sequencer.sv
// Multi-instruction sequencer: fetch, decode, issue and wait on each instruction until HALT; start to first fetch is 1 cycle.
// Handshakes are pulse/level qualified by state; watchdog, instruction limit and abort end a run early.
module program_sequencer #(
    parameter int         DATA_WIDTH     = 8,
    parameter int         MAX_ROWS       = 128,
    parameter int         OUT_N          = 10,
    parameter int         MAX_INSTR      = 1024,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [4:0] HALT_OPCODE    = 5'h00,
    parameter logic [4:0] CAPTURE_OPCODE = 5'h04
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 abort,
    output logic                                 fetch_en_o,
    input  logic                                 fetch_done_i,
    input  logic [4:0]                           opcode_i,
    output logic                                 exec_start_o,
    input  logic                                 exec_done_i,
    input  logic [MAX_ROWS*DATA_WIDTH-1:0]       exec_result_i,
    output logic [OUT_N*DATA_WIDTH-1:0]          y_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 error_o,
    output logic [1:0]                           err_code_o,
    output logic [$clog2(MAX_INSTR+1)-1:0]       instr_count_o
);

    localparam int CW = $clog2(MAX_INSTR + 1);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_LIMIT = CW'(MAX_INSTR);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_LIMIT    = 2'd1;
    localparam logic [1:0] ERR_FETCH_TO = 2'd2;
    localparam logic [1:0] ERR_EXEC_TO  = 2'd3;

    logic [2:0]                  state;
    logic [WW-1:0]               wd;
    logic [4:0]                  op_q;
    logic [CW-1:0]               count;
    logic [1:0]                  err_code;
    logic [OUT_N*DATA_WIDTH-1:0] y;
    logic                        wd_expired;

    assign wd_expired = (wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wd       <= '0;
            op_q     <= '0;
            count    <= '0;
            err_code <= ERR_NONE;
            y        <= '0;
        end else if (abort && (state != S_IDLE)) begin
            // abort keeps y, count and err_code for post-mortem inspection
            state <= S_IDLE;
            wd    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    wd <= '0;
                    if (start) begin
                        state    <= S_FETCH;
                        count    <= '0;
                        err_code <= ERR_NONE;
                    end
                end
                S_FETCH: begin
                    if (fetch_done_i) begin
                        state <= S_DECODE;
                        wd    <= '0;
                    end else if (wd_expired) begin
                        state    <= S_ERROR;
                        err_code <= ERR_FETCH_TO;
                        wd       <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q <= opcode_i;
                    if (opcode_i == HALT_OPCODE) begin
                        state <= S_DONE;
                    end else if (count == COUNT_LIMIT) begin
                        state    <= S_ERROR;
                        err_code <= ERR_LIMIT;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                    wd    <= '0;
                end
                S_WAIT: begin
                    // a completion on the terminal watchdog cycle still counts as success
                    if (exec_done_i) begin
                        count <= count + 1'b1;
                        if (op_q == CAPTURE_OPCODE) begin
                            y <= exec_result_i[OUT_N*DATA_WIDTH-1:0];
                        end
                        state <= S_FETCH;
                        wd    <= '0;
                    end else if (wd_expired) begin
                        state    <= S_ERROR;
                        err_code <= ERR_EXEC_TO;
                        wd       <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    wd    <= '0;
                end
            endcase
        end
    end

    assign fetch_en_o    = (state == S_FETCH);
    assign exec_start_o  = (state == S_ISSUE);
    assign busy_o        = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign done_o        = (state == S_DONE) || (state == S_ERROR);
    assign error_o       = (state == S_ERROR);
    assign err_code_o    = err_code;
    assign instr_count_o = count;
    assign y_o           = y;

    generate
        if (OUT_N < MAX_ROWS) begin : g_unused
            logic unused_lanes;
            assign unused_lanes = ^exec_result_i[MAX_ROWS*DATA_WIDTH-1:OUT_N*DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: each run pushes its expected end-of-run snapshot; the monitor compares when busy_o falls.
module tb_program_sequencer;

    localparam int DW    = 8;
    localparam int ROWS  = 128;
    localparam int ON    = 10;
    localparam int MI    = 3;
    localparam int TO    = 16;
    localparam int CW    = $clog2(MI + 1);
    localparam int YW    = ON * DW;
    localparam int RW    = ROWS * DW;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          fetch_en_o;
    logic          fetch_done_i;
    logic [4:0]    opcode_i;
    logic          exec_start_o;
    logic          exec_done_i;
    logic [RW-1:0] exec_result_i;
    logic [YW-1:0] y_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [1:0]    err_code_o;
    logic [CW-1:0] instr_count_o;

    program_sequencer #(
        .DATA_WIDTH(DW), .MAX_ROWS(ROWS), .OUT_N(ON),
        .MAX_INSTR(MI), .TIMEOUT_CYCLES(TO),
        .HALT_OPCODE(5'h00), .CAPTURE_OPCODE(5'h04)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .fetch_en_o(fetch_en_o), .fetch_done_i(fetch_done_i), .opcode_i(opcode_i),
        .exec_start_o(exec_start_o), .exec_done_i(exec_done_i), .exec_result_i(exec_result_i),
        .y_o(y_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_code_o(err_code_o), .instr_count_o(instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          done;
        logic          err;
        logic [1:0]    code;
        logic [YW-1:0] y;
        int            count;
        int            starts;
        int            cycles;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [4:0]    prog [16];
    logic [RW-1:0] res  [8];
    int            fetch_lat;
    int            exec_lat;
    logic          spur_issue;
    logic          spur_idle;
    logic          exec_done_m;

    assign exec_done_i = exec_done_m | spur_idle;

    function automatic void chk(string nm, logic [YW-1:0] act, logic [YW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void expect_run(logic d, logic er, logic [1:0] c, logic [YW-1:0] yv,
                                       int n, int st, int cy);
        exp_t e;
        e.done = d; e.err = er; e.code = c; e.y = yv;
        e.count = n; e.starts = st; e.cycles = cy;
        q.push_back(e);
    endfunction

    function automatic logic [RW-1:0] res_seq();
        logic [RW-1:0] r;
        for (int i = 0; i < ROWS; i++) r[i*DW +: DW] = DW'(i + 1);
        return r;
    endfunction

    function automatic logic [RW-1:0] res_all(logic [DW-1:0] v);
        logic [RW-1:0] r;
        for (int i = 0; i < ROWS; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    // Fetch / execute responders with configurable latency (0 = same cycle as request)
    initial begin
        int pc;
        int eidx;
        int fcnt;
        int ecnt;
        logic waiting;
        pc = 0; eidx = 0; fcnt = 0; ecnt = 0; waiting = 1'b0;
        fetch_done_i = 1'b0; opcode_i = 5'h1f; exec_done_m = 1'b0; exec_result_i = '0;
        forever begin
            @(negedge clk);
            if (busy_o !== 1'b1) begin
                pc = 0;
                eidx = 0;
            end
            if (fetch_en_o === 1'b1) begin
                if (fcnt == fetch_lat) begin
                    fetch_done_i = 1'b1;
                    opcode_i = (pc < 16) ? prog[pc] : 5'h01;
                    pc++;
                end else begin
                    fetch_done_i = 1'b0;
                end
                fcnt++;
            end else begin
                fetch_done_i = 1'b0;
                fcnt = 0;
            end
            if (exec_start_o === 1'b1) begin
                waiting = 1'b1;
                ecnt = 0;
                exec_done_m = spur_issue;
            end else if (waiting && busy_o === 1'b1) begin
                if (ecnt == exec_lat) begin
                    exec_done_m = 1'b1;
                    exec_result_i = (eidx < 8) ? res[eidx] : '0;
                    eidx++;
                    waiting = 1'b0;
                end else begin
                    exec_done_m = 1'b0;
                end
                ecnt++;
            end else begin
                exec_done_m = 1'b0;
                waiting = 1'b0;
            end
        end
    end

    // Monitor: a run ends whenever busy_o falls
    initial begin
        int bc;
        int sc;
        logic pb;
        exp_t e;
        bc = 0; sc = 0; pb = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_o === 1'b1) bc++;
            if (exec_start_o === 1'b1) sc++;
            if (pb && busy_o !== 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_run_end: got end of run, expected none pending");
                end else begin
                    e = q.pop_front();
                    chk("done", YW'(done_o), YW'(e.done));
                    chk("error", YW'(error_o), YW'(e.err));
                    chk("err_code", YW'(err_code_o), YW'(e.code));
                    chk("y", y_o, e.y);
                    chk("instr_count", YW'(instr_count_o), YW'(e.count));
                    chk("exec_starts", YW'(sc), YW'(e.starts));
                    chk("busy_cycles", YW'(bc), YW'(e.cycles));
                end
                bc = 0;
                sc = 0;
            end
            pb = (busy_o === 1'b1);
        end
    end

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %0d runs pending after %0d cycles, expected 0", q.size(), k);
            q.delete();
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int fl, input int el, input logic sp);
        fetch_lat = fl;
        exec_lat = el;
        spur_issue = sp;
        pulse_start();
        wait_drain();
    endtask

    initial begin
        logic [YW-1:0] yseq;
        logic [YW-1:0] y22;
        logic [YW-1:0] y77;
        int s;
        yseq = res_seq()[YW-1:0];
        y22 = res_all(8'h22)[YW-1:0];
        y77 = res_all(8'h77)[YW-1:0];
        rst = 1'b1; start = 1'b0; abort = 1'b0; spur_idle = 1'b0; spur_issue = 1'b0;
        fetch_lat = 0; exec_lat = 0;
        for (int i = 0; i < 16; i++) prog[i] = 5'h01;
        for (int i = 0; i < 8; i++) res[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_fetch_en", YW'(fetch_en_o), '0);
        chk("rst_exec_start", YW'(exec_start_o), '0);
        chk("rst_busy", YW'(busy_o), '0);
        chk("rst_done", YW'(done_o), '0);
        chk("rst_error", YW'(error_o), '0);
        chk("rst_err_code", YW'(err_code_o), '0);
        chk("rst_y", y_o, '0);
        chk("rst_count", YW'(instr_count_o), '0);
        rst = 1'b0;

        // capture then halt
        prog[0] = 5'h04; prog[1] = 5'h00; res[0] = res_seq();
        expect_run(1'b1, 1'b0, 2'd0, yseq, 1, 1, 6);
        run(0, 0, 1'b0);

        // only the CAPTURE result lands in y
        prog[0] = 5'h01; prog[1] = 5'h04; prog[2] = 5'h02; prog[3] = 5'h00;
        res[0] = res_all(8'h11); res[1] = res_all(8'h22); res[2] = res_all(8'h33);
        expect_run(1'b1, 1'b0, 2'd0, y22, 3, 3, 14);
        run(0, 0, 1'b0);

        // instruction limit reached at the (MI+1)th decode
        for (int i = 0; i < 16; i++) prog[i] = 5'h01;
        expect_run(1'b1, 1'b1, 2'd1, y22, MI, MI, 4 * MI + 2);
        run(0, 0, 1'b0);

        // exec watchdog: 16 WAIT cycles then ERROR
        expect_run(1'b1, 1'b1, 2'd3, y22, 0, 1, 3 + TO);
        run(0, -1, 1'b0);

        // exec_done on the terminal watchdog cycle wins
        prog[0] = 5'h01; prog[1] = 5'h00;
        expect_run(1'b1, 1'b0, 2'd0, y22, 1, 1, 3 + TO + 2);
        run(0, TO - 1, 1'b0);

        // fetch watchdog
        expect_run(1'b1, 1'b1, 2'd2, y22, 0, 0, TO);
        run(-1, 0, 1'b0);

        // abort during WAIT of the second instruction
        prog[0] = 5'h04; prog[1] = 5'h04; prog[2] = 5'h00;
        res[0] = res_seq(); res[1] = res_all(8'hA0);
        fetch_lat = 0; exec_lat = 3; spur_issue = 1'b0;
        expect_run(1'b0, 1'b0, 2'd0, yseq, 1, 2, 11);
        pulse_start();
        s = 0;
        for (int k = 0; k < 100 && s < 2; k++) begin
            @(negedge clk);
            if (exec_start_o === 1'b1) s++;
        end
        if (s < 2) begin
            checks++;
            errors++;
            $display("FAIL abort_setup: got %0d exec_start pulses, expected 2", s);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_drain();

        // restart after abort begins from zero
        prog[0] = 5'h00;
        expect_run(1'b1, 1'b0, 2'd0, yseq, 0, 0, 2);
        run(0, 0, 1'b0);

        // spurious exec_done during ISSUE is ignored
        prog[0] = 5'h04; prog[1] = 5'h00; res[0] = res_all(8'h77);
        expect_run(1'b1, 1'b0, 2'd0, y77, 1, 1, 8);
        run(0, 2, 1'b1);

        // reset mid-FETCH clears everything
        prog[0] = 5'h01;
        fetch_lat = -1; spur_issue = 1'b0;
        expect_run(1'b0, 1'b0, 2'd0, '0, 0, 0, 3);
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_drain();

        // spurious exec_done in IDLE
        spur_idle = 1'b1;
        @(negedge clk);
        spur_idle = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_spur_busy", YW'(busy_o), '0);
        chk("idle_spur_done", YW'(done_o), '0);
        chk("idle_spur_count", YW'(instr_count_o), '0);
        chk("idle_spur_y", y_o, '0);

        prog[0] = 5'h00;
        expect_run(1'b1, 1'b0, 2'd0, '0, 0, 0, 2);
        run(0, 0, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Multi-instruction control sequencer for the tinyML accelerator. It replaces the single-instruction top-level FSM.
- Repeatedly fetches instructions, hands each decoded opcode to the execution unit, and captures result lanes after selected opcodes. It stops on a HALT opcode.
- Adds an instruction-count limit, a per-phase watchdog, abort, and error reporting.
- Sits between fetch_unit/i_decoder and execution_unit in the accelerator top.

Parameters:
- DATA_WIDTH, 8, bits per result element
- MAX_ROWS, 128, number of elements on exec_result_i
- OUT_N, 10, number of result lanes copied to y; must satisfy OUT_N <= MAX_ROWS
- MAX_INSTR, 1024, maximum executed (non-HALT) instructions per run
- TIMEOUT_CYCLES, 4096, maximum cycles spent waiting in FETCH or WAIT_EXEC
- HALT_OPCODE, 5'h00, opcode that terminates the program
- CAPTURE_OPCODE, 5'h04, opcode whose completion updates y

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE, DONE and ERROR
- abort  in  1  cancel the current run
- fetch_en_o  out  1  fetch request to fetch_unit
- fetch_done_i  in  1  fetch_unit reports the instruction is valid
- opcode_i  in  5  decoder opcode; must be stable from the cycle after fetch_done_i until the next fetch
- exec_start_o  out  1  one-cycle start pulse to execution_unit
- exec_done_i  in  1  execution_unit completion pulse
- exec_result_i  in  MAX_ROWS*DATA_WIDTH  packed results; element i is at bits [i*DATA_WIDTH +: DATA_WIDTH]
- y_o  out  OUT_N*DATA_WIDTH  captured results, same packing as exec_result_i
- busy_o  out  1  high in every state except IDLE, DONE and ERROR
- done_o  out  1  high in DONE and in ERROR
- error_o  out  1  high in ERROR
- err_code_o  out  2  0 = none, 1 = instruction limit, 2 = fetch timeout, 3 = exec timeout
- instr_count_o  out  $clog2(MAX_INSTR+1)  number of completed instructions in the current run

Behaviour:
- Reset: the only reset is rst; it is synchronous and active-high.
  - state = IDLE.
  - All outputs = 0, including y_o, instr_count_o and err_code_o.
  - Internal counters = 0.
- Outputs are Moore-decoded from the registered state:
  - fetch_en_o = (state == FETCH)
  - exec_start_o = (state == ISSUE)
  - busy_o and done_o as defined under Ports.
- States:
  - IDLE: when start = 1, clear instr_count and err_code and go to FETCH.
  - FETCH: fetch_en_o = 1. When fetch_done_i = 1, go to DECODE and clear the watchdog. If the watchdog reaches TIMEOUT_CYCLES-1 without fetch_done_i, set err_code = 2 and go to ERROR.
  - DECODE: one-cycle settle state for the decoder; opcode_i is latched here.
    - Latched opcode == HALT_OPCODE: go to DONE.
    - Otherwise, if instr_count == MAX_INSTR: set err_code = 1 and go to ERROR.
    - Otherwise: go to ISSUE.
  - ISSUE: exec_start_o = 1 for exactly one cycle; go to WAIT_EXEC and clear the watchdog.
  - WAIT_EXEC: when exec_done_i = 1:
    - instr_count += 1.
    - If the latched opcode == CAPTURE_OPCODE, y_o <= the low OUT_N elements of exec_result_i, sampled on that same cycle.
    - Go to FETCH.
    - If the watchdog reaches TIMEOUT_CYCLES-1 without exec_done_i, set err_code = 3 and go to ERROR.
  - DONE / ERROR: hold all outputs. When start = 1, restart exactly as from IDLE; err_code clears at that point.
- Watchdog: counts cycles spent in FETCH or WAIT_EXEC and saturates. A timeout fires on the cycle it equals TIMEOUT_CYCLES-1.
- Handshake qualification:
  - fetch_done_i is ignored outside FETCH.
  - exec_done_i is ignored outside WAIT_EXEC, including the ISSUE cycle.
  - If the done pulse and the watchdog terminal count occur in the same cycle, the done pulse wins and no error is raised.
- Abort: abort = 1 in any state except IDLE moves to IDLE on the next edge.
  - Outputs are deasserted.
  - y_o and instr_count_o are retained; err_code is unchanged.
- Priority: rst > abort > start > handshake/watchdog events.
- Latency from start to the first fetch_en_o is 1 cycle. Minimum cost per instruction is FETCH(1) + DECODE(1) + ISSUE(1) + WAIT(1) = 4 cycles.
- y_o is only ever written by a completed CAPTURE_OPCODE instruction. It keeps its value across runs until reset.

Test Plan:
- Program [0x04, 0x00], fetch_done and exec_done each 1 cycle after request, exec_result element i = i+1. Expect:
  - exactly one exec_start pulse;
  - y_o = {1..10};
  - instr_count = 1;
  - done_o = 1, error_o = 0;
  - 5 cycles in FETCH/DECODE/ISSUE/WAIT_EXEC/FETCH before DECODE of the HALT.
- Program [0x01, 0x04, 0x02, 0x00] with result snapshots 0x11, 0x22, 0x33 (all lanes) on each exec_done. Expect:
  - y_o lanes all = 0x22;
  - instr_count = 3;
  - three exec_start pulses.
- MAX_INSTR = 2, program [0x01, 0x01, 0x01, ...]. Expect at the third DECODE: error_o = 1, err_code = 1, done_o = 1, instr_count = 2, and no third exec_start.
- TIMEOUT_CYCLES = 16, exec_done never asserted. Expect ERROR exactly 16 cycles after entering WAIT_EXEC, with err_code = 3. Repeat with exec_done asserted on cycle 15 of the wait: no error, flow proceeds to FETCH.
- abort asserted during WAIT_EXEC of the second instruction. Expect:
  - IDLE next cycle;
  - busy_o = 0, done_o = 0;
  - y_o and instr_count = 1 unchanged;
  - a later start restarts from instr_count = 0.
- rst asserted mid-FETCH, and a spurious exec_done_i pulsed in IDLE and in ISSUE. Expect all outputs = 0 after one edge, and the spurious pulses have no effect on state or counters.
